// File: rtl/syn_pkg.sv
// Shared types and defaults for the sync-frame scheduler.
package syn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_t;

    typedef enum logic {
        SRC_PPS = 1'b0,
        SRC_MAN = 1'b1
    } src_t;

    localparam int unsigned DEF_LOAD_DELAY = 80;
    localparam int unsigned DEF_TX_TIMEOUT = 1023;
    localparam int unsigned DEF_SEC_MAX    = 59;

    function automatic logic [7:0] sec_next(input logic [7:0] s, input logic [7:0] smax);
        return (s == smax) ? '0 : s + 8'd1;
    endfunction

endpackage

// File: rtl/sec_counter.sv
// Broadcast seconds counter with host load, wrap at SEC_MAX, PPS pending flag
// and overrun detection.
module sec_counter
    import syn_pkg::*;
#(
    parameter int unsigned SEC_MAX = DEF_SEC_MAX
) (
    input  logic       clk_10M,
    input  logic       rst_n,
    input  logic       hz,
    input  logic       sec_load,
    input  logic [7:0] sec_load_val,
    input  logic       pps_take,
    input  logic       pps_inflight,
    output logic [7:0] second,
    output logic       pps_pend,
    output logic       err_overrun
);

    logic [7:0] second_q, second_d;
    logic       pps_pend_q, pps_pend_d;
    logic       overrun_q, overrun_d;

    always_comb begin
        second_d   = second_q;
        pps_pend_d = pps_pend_q;
        if (sec_load) begin
            second_d = sec_load_val;
        end else if (hz) begin
            second_d = sec_next(second_q, 8'(SEC_MAX));
        end
        if (pps_take) begin
            pps_pend_d = 1'b0;
        end
        // a new hz always re-arms, even in the cycle the previous one is taken
        if (hz) begin
            pps_pend_d = 1'b1;
        end
        overrun_d = hz & (pps_pend_q | pps_inflight);
    end

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            second_q   <= '0;
            pps_pend_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            second_q   <= second_d;
            pps_pend_q <= pps_pend_d;
            overrun_q  <= overrun_d;
        end
    end

    assign second      = second_q;
    assign pps_pend    = pps_pend_q;
    assign err_overrun = overrun_q;

endmodule

// File: rtl/syn_sched.sv
// Sync-frame scheduler: arbitrates PPS and manual frames, issues start strobes
// to the serial transmitter and supervises completion with a timeout.
module syn_sched
    import syn_pkg::*;
#(
    parameter int unsigned LOAD_DELAY = DEF_LOAD_DELAY,
    parameter int unsigned TX_TIMEOUT = DEF_TX_TIMEOUT,
    parameter int unsigned SEC_MAX    = DEF_SEC_MAX
) (
    input  logic       clk_10M,
    input  logic       rst_n,
    input  logic       hz,
    input  logic       sec_load,
    input  logic [7:0] sec_load_val,
    input  logic       man_req,
    input  logic [7:0] man_data,
    output logic       man_ack,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] second,
    output logic [1:0] state,
    output logic       tx_done,
    output logic       err_timeout,
    output logic       err_overrun
);

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [11:0] tmo_cnt_q, tmo_cnt_d;
    logic        seen_busy_q, seen_busy_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        tx_done_q, tx_done_d;
    logic        err_timeout_q, err_timeout_d;
    logic        man_pend_q, man_pend_d;
    logic [7:0]  man_data_q, man_data_d;
    logic        man_ack_q, man_ack_d;

    logic        pps_pend;
    logic        pps_take;
    logic        pps_inflight;

    // PPS pending is consumed on acceptance so an hz during the frame re-arms it
    assign pps_take     = (state_q == IDLE) && pps_pend && !tx_busy;
    assign pps_inflight = (state_q != IDLE) && (src_q == SRC_PPS);

    sec_counter #(
        .SEC_MAX(SEC_MAX)
    ) u_sec_counter (
        .clk_10M     (clk_10M),
        .rst_n       (rst_n),
        .hz          (hz),
        .sec_load    (sec_load),
        .sec_load_val(sec_load_val),
        .pps_take    (pps_take),
        .pps_inflight(pps_inflight),
        .second      (second),
        .pps_pend    (pps_pend),
        .err_overrun (err_overrun)
    );

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        wait_cnt_d    = wait_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        seen_busy_d   = seen_busy_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        tx_done_d     = 1'b0;
        err_timeout_d = 1'b0;
        man_pend_d    = man_pend_q;
        man_data_d    = man_data_q;
        man_ack_d     = man_req && !man_pend_q;

        if (man_ack_d) begin
            man_pend_d = 1'b1;
            man_data_d = man_data;
        end

        case (state_q)
            IDLE: begin
                if (pps_take) begin
                    state_d    = WAIT;
                    src_d      = SRC_PPS;
                    wait_cnt_d = '0;
                end else if (man_pend_q && !tx_busy) begin
                    state_d    = START;
                    src_d      = SRC_MAN;
                    tx_data_d  = man_data_q;
                    tx_start_d = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 8'(LOAD_DELAY - 1)) begin
                    state_d    = START;
                    tx_data_d  = second;
                    tx_start_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            START: begin
                state_d     = BUSY;
                tmo_cnt_d   = '0;
                seen_busy_d = 1'b0;
            end
            BUSY: begin
                seen_busy_d = seen_busy_q | tx_busy;
                tmo_cnt_d   = tmo_cnt_q + 12'd1;
                if (seen_busy_q && !tx_busy) begin
                    state_d   = IDLE;
                    tx_done_d = 1'b1;
                    if (src_q == SRC_MAN) begin
                        man_pend_d = 1'b0;
                    end
                end else if (tmo_cnt_q == 12'(TX_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                    if (src_q == SRC_MAN) begin
                        man_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_10M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            src_q         <= SRC_PPS;
            wait_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            seen_busy_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_done_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            man_pend_q    <= 1'b0;
            man_data_q    <= '0;
            man_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            wait_cnt_q    <= wait_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            seen_busy_q   <= seen_busy_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            tx_done_q     <= tx_done_d;
            err_timeout_q <= err_timeout_d;
            man_pend_q    <= man_pend_d;
            man_data_q    <= man_data_d;
            man_ack_q     <= man_ack_d;
        end
    end

    assign state       = state_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign tx_done     = tx_done_q;
    assign err_timeout = err_timeout_q;
    assign man_ack     = man_ack_q;

endmodule

// File: tb/tb_syn_sched.sv
// Directed-random bench for syn_sched against a cycle-level reference of the
// frame timing and seconds arithmetic.
module tb_syn_sched;

    localparam int LD   = 80;
    localparam int TMO  = 100;
    localparam int SMAX = 59;

    logic       clk_10M = 1'b0;
    logic       rst_n = 1'b0;
    logic       hz = 1'b0;
    logic       sec_load = 1'b0;
    logic [7:0] sec_load_val = '0;
    logic       man_req = 1'b0;
    logic [7:0] man_data = '0;
    logic       man_ack;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] second;
    logic [1:0] state;
    logic       tx_done;
    logic       err_timeout;
    logic       err_overrun;

    int n_checks = 0;
    int n_fail = 0;
    int exp_sec = 0;
    int cnt_start = 0, cnt_done = 0, cnt_tmo = 0, cnt_ovr = 0, cnt_ack = 0;

    syn_sched #(
        .LOAD_DELAY(LD),
        .TX_TIMEOUT(TMO),
        .SEC_MAX   (SMAX)
    ) dut (
        .clk_10M     (clk_10M),
        .rst_n       (rst_n),
        .hz          (hz),
        .sec_load    (sec_load),
        .sec_load_val(sec_load_val),
        .man_req     (man_req),
        .man_data    (man_data),
        .man_ack     (man_ack),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .second      (second),
        .state       (state),
        .tx_done     (tx_done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #50 clk_10M = ~clk_10M;

    // pulse counters sampled mid-cycle
    always @(negedge clk_10M) begin
        if (tx_start === 1'b1)    cnt_start++;
        if (tx_done === 1'b1)     cnt_done++;
        if (err_timeout === 1'b1) cnt_tmo++;
        if (err_overrun === 1'b1) cnt_ovr++;
        if (man_ack === 1'b1)     cnt_ack++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_10M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int which, input int limit, input string tag, output int cyc);
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < limit) begin
            tick();
            cyc++;
            case (which)
                0:       hit = (tx_start === 1'b1);
                1:       hit = (tx_done === 1'b1);
                default: hit = (err_timeout === 1'b1);
            endcase
        end
        check({tag, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic hz_pulse();
        hz = 1'b1;
        tick();
        hz = 1'b0;
        exp_sec = (exp_sec + 1) % (SMAX + 1);
    endtask

    task automatic finish_frame(input string tag, input int busy_len, input int exp_data);
        tick();
        check({tag, "_busy_state"}, {30'd0, state}, 32'd3);
        check({tag, "_start_width"}, {31'd0, tx_start}, 32'd0);
        tx_busy = 1'b1;
        repeat (busy_len) tick();
        check({tag, "_data_held"}, {24'd0, tx_data}, exp_data);
        tx_busy = 1'b0;
        tick();
        check({tag, "_done"}, {31'd0, tx_done}, 32'd1);
        check({tag, "_idle"}, {30'd0, state}, 32'd0);
        tick();
        check({tag, "_done_width"}, {31'd0, tx_done}, 32'd0);
    endtask

    // caller is one cycle past the edge that sampled hz, plus `skip` cycles
    task automatic pps_frame(input string tag, input int skip, input int busy_len);
        int cyc;
        wait_for(0, LD + 10, {tag, "_start"}, cyc);
        check({tag, "_latency"}, cyc + skip, LD + 1);
        check({tag, "_tx_data"}, {24'd0, tx_data}, exp_sec);
        check({tag, "_start_state"}, {30'd0, state}, 32'd2);
        finish_frame(tag, busy_len, exp_sec);
    endtask

    task automatic man_frame(input string tag, input logic [7:0] d, input int busy_len);
        int a0;
        a0 = cnt_ack;
        man_data = d;
        man_req = 1'b1;
        tick();
        man_req = 1'b0;
        check({tag, "_ack"}, {31'd0, man_ack}, 32'd1);
        tick();
        check({tag, "_start"}, {31'd0, tx_start}, 32'd1);
        check({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, d});
        finish_frame(tag, busy_len, d);
        check({tag, "_ack_count"}, cnt_ack, a0 + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_second"}, {24'd0, second}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_state"}, {30'd0, state}, 32'd0);
        check({tag, "_pulses"}, {27'd0, tx_start, tx_done, err_timeout, err_overrun, man_ack}, 32'd0);
    endtask

    initial begin
        int cyc, s_old, s0, d0, o0, a0, v;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // PPS basic: load 58, one hz, 40-cycle transmission
        sec_load_val = 8'd58;
        sec_load = 1'b1;
        tick();
        sec_load = 1'b0;
        exp_sec = 58;
        check("load_58", {24'd0, second}, exp_sec);
        hz_pulse();
        check("hz_inc", {24'd0, second}, exp_sec);
        check("hz_state_idle", {30'd0, state}, 32'd0);
        pps_frame("pps", 0, 40);

        // wrap 59 -> 0
        hz_pulse();
        check("wrap_second", {24'd0, second}, 32'd0);
        pps_frame("wrap", 0, $urandom_range(1, 60));

        // manual frame alone
        man_frame("man", 8'($urandom), $urandom_range(1, 60));

        // PPS and manual in the same cycle: PPS first, manual right after
        a0 = cnt_ack;
        man_data = 8'hA5;
        man_req = 1'b1;
        hz_pulse();
        check("prio_ack", {31'd0, man_ack}, 32'd1);
        check("prio_second", {24'd0, second}, exp_sec);
        repeat (5) tick();
        man_req = 1'b0;
        pps_frame("prio_pps", 5, $urandom_range(1, 60));
        check("prio_man_start", {31'd0, tx_start}, 32'd1);
        check("prio_man_data", {24'd0, tx_data}, 32'hA5);
        finish_frame("prio_man", $urandom_range(1, 60), 8'hA5);
        check("prio_ack_once", cnt_ack, a0 + 1);

        // timeout: transmitter never reports busy
        hz_pulse();
        wait_for(0, LD + 10, "tmo_start", cyc);
        check("tmo_latency", cyc, LD + 1);
        tick();
        check("tmo_busy_state", {30'd0, state}, 32'd3);
        d0 = cnt_done;
        wait_for(2, TMO + 20, "tmo_pulse", cyc);
        check("tmo_cycles", cyc, TMO);
        check("tmo_idle", {30'd0, state}, 32'd0);
        tick();
        check("tmo_width", {31'd0, err_timeout}, 32'd0);
        s0 = cnt_start;
        repeat (LD + 20) tick();
        check("tmo_no_done", cnt_done, d0);
        check("tmo_dropped", cnt_start, s0);

        // overrun during BUSY of a PPS frame
        hz_pulse();
        s_old = exp_sec;
        wait_for(0, LD + 10, "ovr_start", cyc);
        check("ovr_latency", cyc, LD + 1);
        tick();
        tx_busy = 1'b1;
        repeat (10) tick();
        hz_pulse();
        check("ovr_pulse", {31'd0, err_overrun}, 32'd1);
        check("ovr_second", {24'd0, second}, exp_sec);
        check("ovr_tx_data", {24'd0, tx_data}, s_old);
        repeat (10) tick();
        tx_busy = 1'b0;
        tick();
        check("ovr_done", {31'd0, tx_done}, 32'd1);
        pps_frame("ovr_next", 0, $urandom_range(1, 60));

        // two hz while IDLE is blocked: one overrun, one frame
        o0 = cnt_ovr;
        tx_busy = 1'b1;
        hz_pulse();
        repeat (3) tick();
        hz_pulse();
        check("pend_ovr_pulse", {31'd0, err_overrun}, 32'd1);
        s0 = cnt_start;
        tx_busy = 1'b0;
        pps_frame("pend", 0, $urandom_range(1, 60));
        repeat (LD + 20) tick();
        check("pend_single_frame", cnt_start, s0 + 1);
        check("pend_ovr_count", cnt_ovr, o0 + 1);

        // load and hz together: load wins, frame still scheduled
        v = $urandom_range(0, SMAX);
        sec_load_val = 8'(v);
        sec_load = 1'b1;
        hz = 1'b1;
        tick();
        sec_load = 1'b0;
        hz = 1'b0;
        exp_sec = v;
        check("load_wins", {24'd0, second}, exp_sec);
        pps_frame("load_hz", 0, $urandom_range(1, 60));

        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                hz_pulse();
                check("rnd_second", {24'd0, second}, exp_sec);
                pps_frame("rnd_pps", 0, $urandom_range(1, 60));
            end else begin
                man_frame("rnd_man", 8'($urandom), $urandom_range(1, 60));
            end
        end

        // asynchronous reset in the middle of BUSY
        hz_pulse();
        wait_for(0, LD + 10, "rst_start", cyc);
        tick();
        tx_busy = 1'b1;
        repeat (5) tick();
        d0 = cnt_done;
        #20;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        #30;
        rst_n = 1'b1;
        tx_busy = 1'b0;
        exp_sec = 0;
        s0 = cnt_start;
        repeat (LD + 20) tick();
        check("rst_idle", {30'd0, state}, 32'd0);
        check("rst_no_frame", cnt_start, s0);
        check("rst_no_done", cnt_done, d0);
        check("rst_second", {24'd0, second}, exp_sec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
